// File: rtl/receptor_motor_pkg.sv
// Pattern constants and speed-class encoding shared by the motor bus
// controller and the motor-side receptor.
package motor_pkg;

  localparam logic [7:0] PAT_ZERO   = 8'h00;
  localparam logic [7:0] PAT_LENTO  = 8'h0F;
  localparam logic [7:0] PAT_MEDIO  = 8'h33;
  localparam logic [7:0] PAT_RAPIDO = 8'hC3;

  typedef enum logic [1:0] {
    NIVEL_ZERO   = 2'd0,
    NIVEL_LENTO  = 2'd1,
    NIVEL_MEDIO  = 2'd2,
    NIVEL_RAPIDO = 2'd3
  } nivel_t;

endpackage

// File: rtl/receptor_motor_classificador.sv
// Combinational classifier for one 8-bit pattern bus: flags illegal values,
// non-zero buses and reports the speed class of legal patterns.
module classificador_padrao
  import motor_pkg::*;
(
  input  logic [7:0] padrao,
  output logic       ilegal,
  output logic       nao_zero,
  output nivel_t     nivel
);

  // Illegal patterns still count as non-zero so they also trip the
  // multiple-active check, which gives the same error result anyway.
  always_comb begin
    ilegal   = 1'b0;
    nao_zero = 1'b1;
    nivel    = NIVEL_ZERO;
    case (padrao)
      PAT_ZERO:   nao_zero = 1'b0;
      PAT_LENTO:  nivel    = NIVEL_LENTO;
      PAT_MEDIO:  nivel    = NIVEL_MEDIO;
      PAT_RAPIDO: nivel    = NIVEL_RAPIDO;
      default:    ilegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/receptor_motor.sv
// Motor-side receptor: latches the four pattern buses once per frame, replays
// them serially on pwm and decodes the active motor, speed class and errors.
module receptor_motor
  import motor_pkg::*;
#(
  parameter int DIV = 1
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] motor0,
  input  logic [7:0] motor1,
  input  logic [7:0] motor2,
  input  logic [7:0] motor3,
  output logic [3:0] pwm,
  output logic       ativo_valido,
  output logic [1:0] seletor_rx,
  output logic [1:0] nivel,
  output logic       erro,
  output logic       novo
);

  localparam logic [7:0] PRE_MAX = 8'(DIV - 1);

  logic [7:0] prescaler;
  logic [2:0] bit_idx;
  logic [7:0] pat [4];
  logic [7:0] bus [4];

  logic [3:0] ilegal;
  logic [3:0] nao_zero;
  nivel_t     cls_nivel [4];

  assign bus[0] = motor0;
  assign bus[1] = motor1;
  assign bus[2] = motor2;
  assign bus[3] = motor3;

  for (genvar g = 0; g < 4; g++) begin : g_cls
    classificador_padrao u_cls (
      .padrao   (bus[g]),
      .ilegal   (ilegal[g]),
      .nao_zero (nao_zero[g]),
      .nivel    (cls_nivel[g])
    );
  end

  logic wrap;
  logic fim_quadro;

  assign wrap       = (prescaler == PRE_MAX);
  assign fim_quadro = wrap && (bit_idx == 3'd7);

  logic [2:0] n_ativos;
  logic [1:0] idx_ativo;
  logic       dec_valido;
  logic [1:0] dec_sel;
  nivel_t     dec_nivel;
  logic       dec_erro;

  // Frame decode from the live buses; only used on the frame-end edge.
  always_comb begin
    n_ativos   = 3'd0;
    idx_ativo  = 2'd0;
    dec_valido = 1'b0;
    dec_sel    = 2'd0;
    dec_nivel  = NIVEL_ZERO;
    dec_erro   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (nao_zero[i]) begin
        n_ativos  = n_ativos + 3'd1;
        idx_ativo = 2'(i);
      end
    end
    if ((|ilegal) || (n_ativos > 3'd1)) begin
      dec_erro = 1'b1;
    end else if (n_ativos == 3'd1) begin
      dec_valido = 1'b1;
      dec_sel    = idx_ativo;
      dec_nivel  = cls_nivel[idx_ativo];
    end
  end

  logic [7:0] pre_n;
  logic [2:0] idx_n;
  logic [7:0] pat_n [4];
  logic [3:0] pwm_n;

  // pwm is registered from the next-state pattern and bit index, so bit 0 of a
  // freshly latched pattern appears right after the frame-end edge. An error
  // frame latches all-zero patterns, which keeps every drive line low.
  always_comb begin
    pre_n = wrap ? 8'd0 : prescaler + 8'd1;
    idx_n = wrap ? bit_idx + 3'd1 : bit_idx;
    for (int i = 0; i < 4; i++) begin
      pat_n[i] = pat[i];
      if (fim_quadro) begin
        pat_n[i] = dec_erro ? 8'd0 : bus[i];
      end
      pwm_n[i] = pat_n[i][idx_n];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler    <= 8'd0;
      bit_idx      <= 3'd0;
      for (int i = 0; i < 4; i++) pat[i] <= 8'd0;
      pwm          <= 4'd0;
      ativo_valido <= 1'b0;
      seletor_rx   <= 2'd0;
      nivel        <= 2'd0;
      erro         <= 1'b0;
      novo         <= 1'b0;
    end else begin
      prescaler <= pre_n;
      bit_idx   <= idx_n;
      for (int i = 0; i < 4; i++) pat[i] <= pat_n[i];
      pwm       <= pwm_n;
      novo      <= 1'b0;
      if (fim_quadro) begin
        ativo_valido <= dec_valido;
        seletor_rx   <= dec_sel;
        nivel        <= dec_nivel;
        erro         <= dec_erro;
        novo         <= {dec_valido, dec_sel, dec_nivel, dec_erro} !=
                        {ativo_valido, seletor_rx, nivel, erro};
      end
    end
  end

endmodule

// File: tb/tb_receptor_motor.sv
// Self-checking bench for receptor_motor: DIV=1 and DIV=3 instances share
// inputs and are compared every clock against a frame-level reference model.
module tb_receptor_motor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] m [4];

  logic [3:0] pwm_a, pwm_b;
  logic       val_a, val_b, err_a, err_b, novo_a, novo_b;
  logic [1:0] sel_a, sel_b, niv_a, niv_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  receptor_motor #(.DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .motor0(m[0]), .motor1(m[1]), .motor2(m[2]), .motor3(m[3]),
    .pwm(pwm_a), .ativo_valido(val_a), .seletor_rx(sel_a),
    .nivel(niv_a), .erro(err_a), .novo(novo_a)
  );

  receptor_motor #(.DIV(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .motor0(m[0]), .motor1(m[1]), .motor2(m[2]), .motor3(m[3]),
    .pwm(pwm_b), .ativo_valido(val_b), .seletor_rx(sel_b),
    .nivel(niv_b), .erro(err_b), .novo(novo_b)
  );

  // Reference model: edges since reset, latched frame patterns, decoded state.
  int         divs [2] = '{1, 3};
  int         k    [2];
  logic [7:0] mp   [2][4];
  logic       ev   [2];
  logic [1:0] es   [2];
  logic [1:0] en   [2];
  logic       ee   [2];
  logic       eno  [2];

  function automatic int classe(input logic [7:0] p);
    case (p)
      8'h00:   return 0;
      8'h0F:   return 1;
      8'h33:   return 2;
      8'hC3:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_edge(input int d);
    int nz, c, idx, lv;
    logic bad, nv, ne;
    logic [1:0] ns, nn;
    if (!rst_n) begin
      k[d] = 0;
      for (int i = 0; i < 4; i++) mp[d][i] = 8'h00;
      ev[d] = 0; es[d] = 0; en[d] = 0; ee[d] = 0; eno[d] = 0;
    end else begin
      k[d]++;
      eno[d] = 0;
      if (k[d] % (8 * divs[d]) == 0) begin
        nz = 0; bad = 0; idx = 0; lv = 0;
        for (int i = 0; i < 4; i++) begin
          c = classe(m[i]);
          if (c < 0) bad = 1;
          else if (c > 0) begin nz++; idx = i; lv = c; end
        end
        bad = bad || (nz >= 2);
        nv = !bad && (nz == 1);
        ne = bad;
        ns = nv ? 2'(idx) : 2'd0;
        nn = nv ? 2'(lv) : 2'd0;
        eno[d] = {nv, ns, nn, ne} != {ev[d], es[d], en[d], ee[d]};
        ev[d] = nv; es[d] = ns; en[d] = nn; ee[d] = ne;
        for (int i = 0; i < 4; i++) mp[d][i] = bad ? 8'h00 : m[i];
      end
    end
  endtask

  function automatic logic [10:0] expected(input int d);
    logic [3:0] p;
    int b;
    b = (k[d] / divs[d]) % 8;
    for (int i = 0; i < 4; i++) p[i] = mp[d][i][b];
    return {p, ev[d], es[d], en[d], ee[d], eno[d]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // One clock: model both instances on the edge, compare everything 1 ns later.
  task automatic applyStimulus();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    checkOutput($sformatf("model_div1_k%0d", k[0]),
                32'({pwm_a, val_a, sel_a, niv_a, err_a, novo_a}), 32'(expected(0)));
    checkOutput($sformatf("model_div3_k%0d", k[1]),
                32'({pwm_b, val_b, sel_b, niv_b, err_b, novo_b}), 32'(expected(1)));
  endtask

  task automatic next_frame_a();
    do applyStimulus(); while (k[0] % 8 != 0);
  endtask

  task automatic collect_a(input int ch, input int sw_at, input logic [7:0] sw_val,
                           output logic [7:0] s, output logic [3:0] por);
    s[0] = pwm_a[ch];
    por  = pwm_a;
    for (int j = 1; j < 8; j++) begin
      if (j == sw_at + 1) m[2] = sw_val;
      applyStimulus();
      s[j] = pwm_a[ch];
      por  = por | pwm_a;
    end
  endtask

  task automatic set_bus(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    m[0] = a; m[1] = b; m[2] = c; m[3] = d;
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2, b3;
    logic       v;
    logic [1:0] s;
    logic [1:0] n;
    logic       e;
  } vec_t;

  vec_t vecs [9];

  logic [7:0]  seq;
  logic [3:0]  por;
  logic [23:0] seq_b;
  logic [7:0]  legal [4] = '{8'h00, 8'h0F, 8'h33, 8'hC3};

  initial begin
    vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0};
    vecs[1] = '{8'h0F, 8'h00, 8'h00, 8'h00, 1'b1, 2'd0, 2'd1, 1'b0};
    vecs[2] = '{8'h00, 8'h33, 8'h00, 8'h00, 1'b1, 2'd1, 2'd2, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 8'hC3, 8'h00, 1'b1, 2'd2, 2'd3, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h0F, 1'b1, 2'd3, 2'd1, 1'b0};
    vecs[5] = '{8'h33, 8'h00, 8'h00, 8'hC3, 1'b0, 2'd0, 2'd0, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 2'd0, 2'd0, 1'b1};
    vecs[7] = '{8'hF0, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 2'd0, 1'b1};
    vecs[8] = '{8'h00, 8'h0F, 8'h33, 8'hC3, 1'b0, 2'd0, 2'd0, 1'b1};

    // Reset held with random legal buses.
    rst_n = 1'b0;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 4; i++) m[i] = legal[$urandom_range(3)];
      applyStimulus();
      checkOutput("reset_outputs_zero",
                  32'({pwm_a, val_a, sel_a, niv_a, err_a, novo_a, pwm_b, val_b, sel_b, niv_b, err_b, novo_b}), 32'd0);
    end

    // Single motor 2 at 33h; first load at edge 8.
    set_bus(8'h00, 8'h00, 8'h33, 8'h00);
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) applyStimulus();
    checkOutput("first_frame_decode", 32'({val_a, sel_a, niv_a, err_a, novo_a}), 32'b1_10_10_0_1);
    collect_a(2, -1, 8'h00, seq, por);
    checkOutput("pwm2_33h", 32'(seq), 32'h33);
    checkOutput("pwm_other_bits", 32'(por & 4'b1011), 32'd0);

    // Switch to C3h mid-frame; takes effect only at the next frame.
    applyStimulus();
    collect_a(2, 3, 8'hC3, seq, por);
    checkOutput("pwm2_finish_33h", 32'(seq), 32'h33);
    applyStimulus();
    checkOutput("c3_decode_novo", 32'({val_a, sel_a, niv_a, err_a, novo_a}), 32'b1_10_11_0_1);
    collect_a(2, -1, 8'h00, seq, por);
    checkOutput("pwm2_c3h", 32'(seq), 32'hC3);

    // Two active motors: error, pwm silenced for the whole frame.
    set_bus(8'h0F, 8'h0F, 8'h00, 8'h00);
    next_frame_a();
    checkOutput("two_active_err", 32'({val_a, err_a}), 32'b01);
    collect_a(0, -1, 8'h00, seq, por);
    checkOutput("two_active_pwm_zero", 32'(por), 32'd0);
    m[1] = 8'h00;
    next_frame_a();
    checkOutput("restore_motor0", 32'({val_a, sel_a, niv_a, err_a}), 32'b1_00_01_0);

    // Illegal pattern held for three frames: novo only on the first.
    set_bus(8'h00, 8'h00, 8'h00, 8'h55);
    next_frame_a();
    checkOutput("illegal_err_novo", 32'({err_a, novo_a}), 32'b11);
    for (int f = 0; f < 2; f++) begin
      next_frame_a();
      checkOutput("illegal_hold_novo", 32'({err_a, novo_a}), 32'b10);
    end

    // Table-driven decode on the DIV=1 instance.
    for (int v = 0; v < 9; v++) begin
      set_bus(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3);
      next_frame_a();
      checkOutput($sformatf("table_vec%0d", v), 32'({val_a, sel_a, niv_a, err_a}),
                  32'({vecs[v].v, vecs[v].s, vecs[v].n, vecs[v].e}));
    end

    // DIV=3: 24-clock frame, 3 clocks per bit, mid-frame reset.
    set_bus(8'h00, 8'h0F, 8'h00, 8'h00);
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int t = 0; t < 23; t++) applyStimulus();
      checkOutput("div3_before_load", 32'(val_b), 32'd0);
      applyStimulus();
      checkOutput("div3_load_edge24", 32'({val_b, sel_b, niv_b, err_b}), 32'b1_01_01_0);
      if (r == 1) break;
      seq_b[0] = pwm_b[1];
      for (int t = 1; t < 24; t++) begin
        applyStimulus();
        seq_b[t] = pwm_b[1];
      end
      checkOutput("div3_pwm1_held3", 32'(seq_b), 32'h000FFF);
      for (int t = 0; t < 10; t++) applyStimulus();
      rst_n = 1'b0;
      applyStimulus();
      checkOutput("div3_midframe_reset",
                  32'({pwm_a, val_a, sel_a, niv_a, err_a, novo_a, pwm_b, val_b, sel_b, niv_b, err_b, novo_b}), 32'd0);
      rst_n = 1'b1;
    end

    // Randomized buses with occasional resets, checked against the model.
    for (int t = 0; t < 2000; t++) begin
      rst_n = ($urandom_range(199) != 0);
      if ($urandom_range(5) == 0) begin
        if ($urandom_range(3) == 0) m[$urandom_range(3)] = 8'($urandom);
        else m[$urandom_range(3)] = legal[$urandom_range(3)];
      end
      if ($urandom_range(39) == 0) set_bus(8'h00, 8'h00, 8'h00, 8'h00);
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
